// File: rtl/operand_regfile.sv
// ---------------------------------------------------------------------------
// operand_regfile
//
// Operand register bank for the 16-bit CPU datapath. Holds NREGS registers of
// WIDTH bits loaded from the data-memory output bus. It has two combinational
// read ports for the ALU, a per-register pending scoreboard that tracks
// outstanding memory loads, and an atomic two-register swap.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (clears registers and pending)
//   wr_en        write datamem_out into register wr_addr (clears its pending)
//   wr_addr      write address
//   datamem_out  write data from data memory
//   pend_set     mark register pend_addr as pending (load issued)
//   pend_addr    pending-set address
//   swap_en      exchange registers rd_addr_a / rd_addr_b and their pending bits
//   rd_addr_a/b  read port addresses
//   rd_data_a/b  register contents at rd_addr_a/b
//   rd_ready_a/b register at rd_addr_a/b is not pending
//   pending      per-register pending flags, bit i = register i
//
// Configuration macro:
//   OPERAND_REGFILE_BYPASS_EN  when defined, a same-cycle write to a read
//                              address is forwarded to that read port.
// ---------------------------------------------------------------------------
module operand_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] datamem_out,
    input  logic             pend_set,
    input  logic [AW-1:0]    pend_addr,
    input  logic             swap_en,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_ready_a,
    output logic             rd_ready_b,
    output logic [NREGS-1:0] pending
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Next-state: later statements override earlier ones, giving the
    // priority swap < write < pend_set on a shared address.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;

        // A self-swap (a == b) is a no-op, so skip it outright.
        if (swap_en && (rd_addr_a != rd_addr_b)) begin
            regs_d[rd_addr_a]    = regs_q[rd_addr_b];
            regs_d[rd_addr_b]    = regs_q[rd_addr_a];
            pending_d[rd_addr_a] = pending_q[rd_addr_b];
            pending_d[rd_addr_b] = pending_q[rd_addr_a];
        end

        if (wr_en) begin
            regs_d[wr_addr]    = datamem_out;
            pending_d[wr_addr] = 1'b0;
        end

        if (pend_set) begin
            pending_d[pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

`ifdef OPERAND_REGFILE_BYPASS_EN
    // Write-through forwarding; deliberately independent of swap_en.
    always_comb begin
        rd_data_a  = regs_q[rd_addr_a];
        rd_ready_a = ~pending_q[rd_addr_a];
        rd_data_b  = regs_q[rd_addr_b];
        rd_ready_b = ~pending_q[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a  = datamem_out;
            rd_ready_a = 1'b1;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b  = datamem_out;
            rd_ready_b = 1'b1;
        end
    end
`else
    always_comb begin
        rd_data_a  = regs_q[rd_addr_a];
        rd_ready_a = ~pending_q[rd_addr_a];
        rd_data_b  = regs_q[rd_addr_b];
        rd_ready_b = ~pending_q[rd_addr_b];
    end
`endif

endmodule

// File: tb/tb_operand_regfile.sv
module tb_operand_regfile;

    localparam int WIDTH = 16;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] datamem_out;
    logic             pend_set;
    logic [AW-1:0]    pend_addr;
    logic             swap_en;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_ready_a;
    logic             rd_ready_b;
    logic [NREGS-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    operand_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .datamem_out(datamem_out),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .swap_en    (swap_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_ready_a (rd_ready_a),
        .rd_ready_b (rd_ready_b),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        pend_set = 1'b0;
        swap_en  = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; datamem_out = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        wr_addr = '0; datamem_out = '0; pend_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        reset = 1'b1;
        tick();
        idle();

        // Reset clears a previously loaded register
        write(2'd0, 16'h1234);
        rd_addr_a = 2'd0; #1;
        chk("load_reg0", rd_data_a, 16'h1234);
        write(2'd2, 16'h4444);
        reset = 1'b1; tick(); idle();
        for (int i = 0; i < NREGS; i++) begin
            rd_addr_a = AW'(i); #1;
            chk($sformatf("rst_reg%0d", i), rd_data_a, 16'h0000);
        end
        chk("rst_pending", pending, 4'b0000);
        chk("rst_ready_a", rd_ready_a, 1'b1);
        chk("rst_ready_b", rd_ready_b, 1'b1);

        // Load and read on both ports
        write(2'd1, 16'hA5A5);
        write(2'd2, 16'h5A5A);
        rd_addr_a = 2'd1; rd_addr_b = 2'd2; #1;
        chk("rd_a_reg1", rd_data_a, 16'hA5A5);
        chk("rd_b_reg2", rd_data_b, 16'h5A5A);
        rd_addr_b = 2'd1; #1;
        chk("rd_b_same_addr", rd_data_b, 16'hA5A5);

        // Scoreboard
        pend_set = 1'b1; pend_addr = 2'd3; tick(); idle();
        rd_addr_a = 2'd3; #1;
        chk("pend_vec", pending, 4'b1000);
        chk("pend_ready_a", rd_ready_a, 1'b0);
        write(2'd3, 16'h00FF);
        chk("pend_clr_vec", pending, 4'b0000);
        chk("pend_clr_data", rd_data_a, 16'h00FF);
        chk("pend_clr_ready", rd_ready_a, 1'b1);
        pend_set = 1'b1; pend_addr = 2'd3;
        write(2'd3, 16'h0F0F);
        chk("pend_wr_same_vec", pending, 4'b1000);
        chk("pend_wr_same_data", rd_data_a, 16'h0F0F);

        // Swap with pending bit exchange
        write(2'd3, 16'h3333);
        write(2'd0, 16'h1111);
        pend_set = 1'b1; pend_addr = 2'd1;
        write(2'd1, 16'h2222);
        chk("pre_swap_pend", pending, 4'b0010);
        rd_addr_a = 2'd0; rd_addr_b = 2'd1; swap_en = 1'b1; #1;
        chk("swap_not_early", rd_data_a, 16'h1111);
        tick(); idle();
        chk("swap_a", rd_data_a, 16'h2222);
        chk("swap_b", rd_data_b, 16'h1111);
        chk("swap_pend", pending, 4'b0001);
        chk("swap_ready_a", rd_ready_a, 1'b0);
        chk("swap_ready_b", rd_ready_b, 1'b1);
        rd_addr_a = 2'd2; rd_addr_b = 2'd2; swap_en = 1'b1; tick(); idle();
        chk("self_swap_data", rd_data_a, 16'h5A5A);
        chk("self_swap_pend", pending, 4'b0001);

        // Write overrides swap on the same register
        rd_addr_a = 2'd0; rd_addr_b = 2'd1; swap_en = 1'b1;
        write(2'd0, 16'hBEEF);
        chk("wr_over_swap_a", rd_data_a, 16'hBEEF);
        chk("wr_over_swap_b", rd_data_b, 16'h2222);
        chk("wr_over_swap_pend", pending, 4'b0010);

        // Same-cycle read of a register being written (reg1 pending)
        rd_addr_a = 2'd1; rd_addr_b = 2'd0;
        wr_en = 1'b1; wr_addr = 2'd1; datamem_out = 16'hCAFE; #1;
`ifdef OPERAND_REGFILE_BYPASS_EN
        chk("bypass_data", rd_data_a, 16'hCAFE);
        chk("bypass_ready", rd_ready_a, 1'b1);
`else
        chk("nobypass_data", rd_data_a, 16'h2222);
        chk("nobypass_ready", rd_ready_a, 1'b0);
`endif
        chk("bypass_other_port", rd_data_b, 16'hBEEF);
        tick(); idle();
        chk("after_edge_data", rd_data_a, 16'hCAFE);
        chk("after_edge_ready", rd_ready_a, 1'b1);

        // Reset with a load outstanding, then an ordinary write
        pend_set = 1'b1; pend_addr = 2'd2; tick(); idle();
        chk("mid_pend", pending, 4'b0100);
        reset = 1'b1; pend_set = 1'b1; pend_addr = 2'd3;
        write(2'd3, 16'h9999);
        chk("mid_rst_pend", pending, 4'b0000);
        chk("mid_rst_data", rd_data_a, 16'h0000);
        write(2'd2, 16'h7777);
        rd_addr_a = 2'd2; #1;
        chk("post_rst_wr", rd_data_a, 16'h7777);
        chk("post_rst_ready", rd_ready_a, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
